mem_request_arbiter: RTL and testbench

- Shares one SRAM-like memory request channel between the instruction-fetch requester and the data load/store requester.
- Sits between the pipeline and the CPU-side port of the AXI bridge. It runs a single outstanding transaction at a time.
- Data accesses have priority, and a starvation counter bounds the fetch wait.
- Request fields are latched at grant, so the downstream side sees stable values.

---
 rtl/mem_request_arbiter_if.sv | 25 ++
 rtl/mem_request_arbiter_checker.sv | 15 +
 rtl/mem_request_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_request_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_arbiter_if.sv
// SRAM-like request channel: one requester (master) drives request fields,
// the responder (slave) answers with address/data ready pulses and read data.
interface mem_request_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     request;
  logic                     write;
  logic [1:0]               size;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     address_ready;
  logic                     data_ready;
  logic [DATA_WIDTH-1:0]    read_data;

  modport master (
    output request, write, size, address, write_data,
    input  address_ready, data_ready, read_data
  );

  modport slave (
    input  request, write, size, address, write_data,
    output address_ready, data_ready, read_data
  );
endinterface

// File: rtl/mem_request_arbiter_checker.sv
// Protocol checker for the arbiter: downstream completion is only legal
// while a transaction is waiting for its data phase.
module mem_request_arbiter_checker (
  input logic clock,
  input logic reset,
  input logic in_wait,
  input logic mem_data_ready
);
  // A data_ready in IDLE or an address phase is a downstream protocol error.
  always @(posedge clock) begin
    if (!reset && mem_data_ready && !in_wait) begin
      $error("mem_request_arbiter: mem_data_ready outside a WAIT state");
    end
  end
endmodule

// File: rtl/mem_request_arbiter.sv
// Shares one memory request channel between fetch and load/store requesters,
// data first, with a starvation bound on fetch; one transaction in flight.
module mem_request_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input logic                  clock,
  input logic                  reset,
  mem_request_arbiter_if.slave  inst,
  mem_request_arbiter_if.slave  data,
  mem_request_arbiter_if.master mem
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_INST = 3'd1,
    ADDR_DATA = 3'd2,
    WAIT_INST = 3'd3,
    WAIT_DATA = 3'd4
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [3:0]               starve_count;
  logic                     hold_write;
  logic [1:0]               hold_size;
  logic [ADDRESS_WIDTH-1:0] hold_address;
  logic [DATA_WIDTH-1:0]    hold_write_data;
  logic                     starved;
  logic                     grant_data;
  logic                     grant_inst;
  logic                     in_wait;

  // Fetch wins only once it has watched LIMIT data grants go by.
  assign starved    = inst.request && (starve_count == LIMIT);
  assign grant_data = (state == IDLE) && data.request && !starved;
  assign grant_inst = (state == IDLE) && inst.request && !grant_data;
  assign in_wait    = (state == WAIT_INST) || (state == WAIT_DATA);

  assign mem.write      = hold_write;
  assign mem.size       = hold_size;
  assign mem.address    = hold_address;
  assign mem.write_data = hold_write_data;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake steering; read data is passed through unregistered.
  always_comb begin
    next_state         = state;
    mem.request        = 1'b0;
    inst.address_ready = 1'b0;
    inst.data_ready    = 1'b0;
    inst.read_data     = '0;
    data.address_ready = 1'b0;
    data.data_ready    = 1'b0;
    data.read_data     = '0;
    case (state)
      IDLE: begin
        if (grant_data) begin
          next_state = ADDR_DATA;
        end else if (grant_inst) begin
          next_state = ADDR_INST;
        end else begin
          next_state = IDLE;
        end
      end
      ADDR_INST: begin
        mem.request        = 1'b1;
        inst.address_ready = mem.address_ready;
        if (mem.address_ready) begin
          next_state = WAIT_INST;
        end else begin
          next_state = ADDR_INST;
        end
      end
      ADDR_DATA: begin
        mem.request        = 1'b1;
        data.address_ready = mem.address_ready;
        if (mem.address_ready) begin
          next_state = WAIT_DATA;
        end else begin
          next_state = ADDR_DATA;
        end
      end
      WAIT_INST: begin
        inst.data_ready = mem.data_ready;
        inst.read_data  = mem.read_data;
        if (mem.data_ready) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_INST;
        end
      end
      WAIT_DATA: begin
        data.data_ready = mem.data_ready;
        data.read_data  = mem.read_data;
        if (mem.data_ready) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_DATA;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the winner's request fields so downstream sees them stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_write      <= 1'b0;
      hold_size       <= 2'd0;
      hold_address    <= '0;
      hold_write_data <= '0;
    end else if (grant_data) begin
      hold_write      <= data.write;
      hold_size       <= data.size;
      hold_address    <= data.address;
      hold_write_data <= data.write_data;
    end else if (grant_inst) begin
      hold_write      <= inst.write;
      hold_size       <= inst.size;
      hold_address    <= inst.address;
      hold_write_data <= inst.write_data;
    end
  end

  // Count data grants that jumped ahead of a waiting fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_count <= 4'd0;
    end else if (grant_inst) begin
      starve_count <= 4'd0;
    end else if (grant_data && inst.request && (starve_count != LIMIT)) begin
      starve_count <= starve_count + 4'd1;
    end
  end

  mem_request_arbiter_checker u_checker (
    .clock          (clock),
    .reset          (reset),
    .in_wait        (in_wait),
    .mem_data_ready (mem.data_ready)
  );
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: hand-computed expectations for
// fetch, priority, starvation, latching, reset and back-to-back traffic.
module tb_mem_request_arbiter;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   start_cyc;

  mem_request_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) inst_bus ();
  mem_request_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) data_bus ();
  mem_request_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  mem_request_arbiter #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .STARVE_LIMIT  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .mem   (mem_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Zero-wait transaction starting from an IDLE cycle; ends in the next IDLE cycle.
  task automatic xact(input string tag, input logic is_inst, input logic [31:0] exp_addr,
                      input logic exp_write, input logic [31:0] exp_wdata, input logic [31:0] rdata);
    step();
    check({tag, "_req"}, 64'(mem_bus.request), 64'd1);
    check({tag, "_addr"}, 64'(mem_bus.address), 64'(exp_addr));
    check({tag, "_write"}, 64'(mem_bus.write), 64'(exp_write));
    check({tag, "_wdata"}, 64'(mem_bus.write_data), 64'(exp_wdata));
    mem_bus.address_ready = 1'b1;
    #1;
    check({tag, "_ardy"}, 64'(is_inst ? inst_bus.address_ready : data_bus.address_ready), 64'd1);
    check({tag, "_ardy_other"}, 64'(is_inst ? data_bus.address_ready : inst_bus.address_ready), 64'd0);
    step();
    mem_bus.address_ready = 1'b0;
    check({tag, "_req_wait"}, 64'(mem_bus.request), 64'd0);
    mem_bus.data_ready = 1'b1;
    mem_bus.read_data  = rdata;
    #1;
    check({tag, "_drdy"}, 64'(is_inst ? inst_bus.data_ready : data_bus.data_ready), 64'd1);
    check({tag, "_rdata"}, 64'(is_inst ? inst_bus.read_data : data_bus.read_data), 64'(rdata));
    check({tag, "_drdy_other"}, 64'(is_inst ? data_bus.data_ready : inst_bus.data_ready), 64'd0);
    step();
    mem_bus.data_ready = 1'b0;
    mem_bus.read_data  = 32'd0;
    check({tag, "_idle_req"}, 64'(mem_bus.request), 64'd0);
    check({tag, "_pulse"}, 64'(is_inst ? inst_bus.data_ready : data_bus.data_ready), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    inst_bus.request = 1'b0; inst_bus.write = 1'b0; inst_bus.size = 2'd0;
    inst_bus.address = 32'd0; inst_bus.write_data = 32'd0;
    data_bus.request = 1'b0; data_bus.write = 1'b0; data_bus.size = 2'd0;
    data_bus.address = 32'd0; data_bus.write_data = 32'd0;
    mem_bus.address_ready = 1'b0; mem_bus.data_ready = 1'b0; mem_bus.read_data = 32'd0;

    #3;
    check("rst_req", 64'(mem_bus.request), 64'd0);
    check("rst_addr", 64'(mem_bus.address), 64'd0);
    check("rst_starve", 64'(dut.starve_count), 64'd0);
    #4 reset = 1'b0;
    step();

    // Single fetch: address ack after one cycle, data two cycles later.
    inst_bus.request = 1'b1; inst_bus.address = 32'hBFC00000; inst_bus.size = 2'd2;
    #1;
    check("sf_req_c0", 64'(mem_bus.request), 64'd0);
    step();
    check("sf_req_c1", 64'(mem_bus.request), 64'd1);
    check("sf_addr", 64'(mem_bus.address), 64'hBFC00000);
    check("sf_size", 64'(mem_bus.size), 64'd2);
    check("sf_ardy_early", 64'(inst_bus.address_ready), 64'd0);
    step();
    check("sf_req_hold", 64'(mem_bus.request), 64'd1);
    mem_bus.address_ready = 1'b1;
    #1;
    check("sf_ardy", 64'(inst_bus.address_ready), 64'd1);
    check("sf_data_ardy", 64'(data_bus.address_ready), 64'd0);
    step();
    mem_bus.address_ready = 1'b0;
    inst_bus.request = 1'b0;
    check("sf_ardy_pulse", 64'(inst_bus.address_ready), 64'd0);
    check("sf_drdy_early", 64'(inst_bus.data_ready), 64'd0);
    step();
    mem_bus.data_ready = 1'b1; mem_bus.read_data = 32'h3C1D0001;
    #1;
    check("sf_drdy", 64'(inst_bus.data_ready), 64'd1);
    check("sf_rdata", 64'(inst_bus.read_data), 64'h3C1D0001);
    check("sf_data_drdy", 64'(data_bus.data_ready), 64'd0);
    step();
    mem_bus.data_ready = 1'b0; mem_bus.read_data = 32'd0;
    check("sf_drdy_pulse", 64'(inst_bus.data_ready), 64'd0);
    check("sf_idle_req", 64'(mem_bus.request), 64'd0);

    // Simultaneous requests: data write wins, fetch follows after an IDLE cycle.
    inst_bus.request = 1'b1; inst_bus.address = 32'h00400000;
    data_bus.request = 1'b1; data_bus.write = 1'b1; data_bus.size = 2'd2;
    data_bus.address = 32'h80001000; data_bus.write_data = 32'h12345678;
    xact("sim_d", 1'b0, 32'h80001000, 1'b1, 32'h12345678, 32'h0);
    data_bus.request = 1'b0; data_bus.write = 1'b0; data_bus.write_data = 32'd0;
    check("sim_starve", 64'(dut.starve_count), 64'd1);
    xact("sim_i", 1'b1, 32'h00400000, 1'b0, 32'h0, 32'h11110000);
    check("sim_starve_clr", 64'(dut.starve_count), 64'd0);

    // Starvation: four data grants, then the fetch, then data again.
    inst_bus.address = 32'h00001000;
    data_bus.request = 1'b1; data_bus.address = 32'h00002000;
    for (int i = 0; i < 4; i++) begin
      xact("stv_d", 1'b0, 32'h00002000, 1'b0, 32'h0, 32'hD0 + 32'(i));
      check("stv_count", 64'(dut.starve_count), 64'(i + 1));
    end
    xact("stv_i", 1'b1, 32'h00001000, 1'b0, 32'h0, 32'hF00D);
    check("stv_clr", 64'(dut.starve_count), 64'd0);
    xact("stv_d2", 1'b0, 32'h00002000, 1'b0, 32'h0, 32'hD9);
    check("stv_again", 64'(dut.starve_count), 64'd1);
    inst_bus.request = 1'b0;
    data_bus.request = 1'b0;

    // Input change after grant: latched address must not move.
    data_bus.request = 1'b1; data_bus.address = 32'h00000100;
    step();
    data_bus.address = 32'h00000200;
    data_bus.request = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("chg_addr", 64'(mem_bus.address), 64'h100);
      check("chg_req", 64'(mem_bus.request), 64'd1);
      step();
    end
    mem_bus.address_ready = 1'b1;
    #1;
    check("chg_ardy", 64'(data_bus.address_ready), 64'd1);
    step();
    mem_bus.address_ready = 1'b0;
    mem_bus.data_ready = 1'b1;
    step();
    mem_bus.data_ready = 1'b0;
    check("chg_starve", 64'(dut.starve_count), 64'd1);

    // Reset asserted mid-cycle in WAIT_DATA.
    inst_bus.request = 1'b1; inst_bus.address = 32'h00004000;
    data_bus.request = 1'b1; data_bus.write = 1'b1;
    data_bus.address = 32'h00000300; data_bus.write_data = 32'h000000AA;
    step();
    mem_bus.address_ready = 1'b1;
    step();
    mem_bus.address_ready = 1'b0;
    mem_bus.data_ready = 1'b1; mem_bus.read_data = 32'hDEAD;
    #1;
    check("rw_drdy", 64'(data_bus.data_ready), 64'd1);
    check("rw_starve_pre", 64'(dut.starve_count), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("rw_req", 64'(mem_bus.request), 64'd0);
    check("rw_write", 64'(mem_bus.write), 64'd0);
    check("rw_addr", 64'(mem_bus.address), 64'd0);
    check("rw_wdata", 64'(mem_bus.write_data), 64'd0);
    check("rw_drdy0", 64'(data_bus.data_ready), 64'd0);
    check("rw_rdata0", 64'(data_bus.read_data), 64'd0);
    check("rw_starve", 64'(dut.starve_count), 64'd0);
    mem_bus.data_ready = 1'b0; mem_bus.read_data = 32'd0;
    data_bus.request = 1'b0; data_bus.write = 1'b0; data_bus.write_data = 32'd0;
    #2 reset = 1'b0;
    xact("rw_i", 1'b1, 32'h00004000, 1'b0, 32'h0, 32'h5A5A);
    check("rw_starve_post", 64'(dut.starve_count), 64'd0);

    // Back-to-back fetches: one transaction every three cycles.
    start_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      inst_bus.address = 32'h00008000 + 32'(i * 4);
      xact("b2b", 1'b1, 32'h00008000 + 32'(i * 4), 1'b0, 32'h0, 32'hA0 + 32'(i));
    end
    check("b2b_cycles", 64'(cyc - start_cyc), 64'd9);
    inst_bus.request = 1'b0;
    step();
    check("end_idle", 64'(mem_bus.request), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
